// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for the single-cycle MIPS core: issues one-clock CPU enables,
// counts executed instructions, enforces a cycle limit and a PC breakpoint, and muxes the display.
module cpu_run_ctrl #(
  parameter int unsigned MAX_CYCLES = 2048,
  parameter int unsigned DIV_SHIFT  = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             clr_i,
  input  logic [1:0]       rate_sel_i,
  input  logic             bp_en_i,
  input  logic [31:0]      bp_addr_i,
  input  logic [31:0]      pc_i,
  input  logic             reg_wr_i,
  input  logic             mem_wr_i,
  input  logic [31:0]      wb_data_i,
  input  logic [31:0]      st_data_i,
  output logic             cpu_en_o,
  output logic             halted_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] icount_o,
  output logic [31:0]      display_o
);

  localparam int unsigned      PreW   = 3 * DIV_SHIFT;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StHalt = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic [PreW-1:0]  presc_q, presc_d, presc_mask;
  logic             skip_q, skip_d;
  logic             step_s1_q, step_s2_q, step_s3_q;
  logic             run_q;
  logic [31:0]      display_q;

  logic step_req, run_rise, tick, at_limit, bp_hit;

  assign step_req = step_s2_q & ~step_s3_q;
  assign run_rise = run_i & ~run_q;
  assign at_limit = (icount_q >= MaxCnt);
  assign bp_hit   = bp_en_i && (pc_i == bp_addr_i) && !skip_q;

  // rate_sel=0 gives an empty mask, so the compare below ticks every clock.
  always_comb begin
    presc_mask = '0;
    for (int unsigned i = 0; i < PreW; i++) begin
      if (i < 32'(rate_sel_i) * DIV_SHIFT) presc_mask[i] = 1'b1;
    end
  end

  assign tick = ((presc_q & presc_mask) == presc_mask);

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    skip_d   = skip_q;
    presc_d  = presc_q + PreW'(1);

    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          state_d = StRun;
        end else if (step_req) begin
          if (at_limit) begin
            state_d = StHalt;
          end else begin
            state_d  = StStep;
            cpu_en_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (tick) begin
          if (at_limit || bp_hit) begin
            state_d = StHalt;
          end else begin
            cpu_en_d = 1'b1;
            skip_d   = 1'b0;
            if (!run_i) state_d = StIdle;
          end
        end else if (!run_i) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        state_d = StIdle;
      end
      StHalt: begin
        if (run_rise && !at_limit) begin
          state_d = StRun;
          // Let the instruction sitting on the breakpoint execute once.
          skip_d  = 1'b1;
        end else if (step_req && !at_limit) begin
          cpu_en_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr_i) begin
      state_d  = StIdle;
      cpu_en_d = 1'b0;
      skip_d   = 1'b0;
    end

    if ((state_d == StRun) && (state_q != StRun)) presc_d = '0;

    if (clr_i) begin
      icount_d = '0;
    end else if (cpu_en_d && !at_limit) begin
      icount_d = icount_q + CNT_W'(1);
    end else begin
      icount_d = icount_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cpu_en_q  <= 1'b0;
      icount_q  <= '0;
      presc_q   <= '0;
      skip_q    <= 1'b0;
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
      run_q     <= 1'b0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      icount_q  <= icount_d;
      presc_q   <= presc_d;
      skip_q    <= skip_d;
      step_s1_q <= step_i;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
      run_q     <= run_i;
      display_q <= reg_wr_i ? wb_data_i : (mem_wr_i ? st_data_i : pc_i);
    end
  end

  assign cpu_en_o  = cpu_en_q;
  assign halted_o  = (state_q == StHalt);
  assign state_o   = state_q;
  assign icount_o  = icount_q;
  assign display_o = display_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios with randomized timing and data,
// expected values derived from the run/step/halt rules with simple arithmetic.
module tb_cpu_run_ctrl;

  localparam int unsigned MaxCycles = 2048;
  localparam int unsigned DivShift  = 8;
  localparam int unsigned CntW      = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run_i = 1'b0;
  logic            step_i = 1'b0;
  logic            clr_i = 1'b0;
  logic [1:0]      rate_sel_i = 2'd0;
  logic            bp_en_i = 1'b0;
  logic [31:0]     bp_addr_i = '0;
  logic [31:0]     pc_drv = '0;
  logic            cpu_mode = 1'b0;
  logic            reg_wr_i = 1'b0;
  logic            mem_wr_i = 1'b0;
  logic [31:0]     wb_data_i = '0;
  logic [31:0]     st_data_i = '0;
  logic [31:0]     pc_i;
  logic            cpu_en_o;
  logic            halted_o;
  logic [1:0]      state_o;
  logic [CntW-1:0] icount_o;
  logic [31:0]     display_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_times[$];

  // CPU stand-in: PC points at the next instruction to execute.
  assign pc_i = cpu_mode ? (32'h0000_3000 + (icount_o << 2)) : pc_drv;

  cpu_run_ctrl #(
    .MAX_CYCLES(MaxCycles),
    .DIV_SHIFT (DivShift),
    .CNT_W     (CntW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run_i     (run_i),
    .step_i    (step_i),
    .clr_i     (clr_i),
    .rate_sel_i(rate_sel_i),
    .bp_en_i   (bp_en_i),
    .bp_addr_i (bp_addr_i),
    .pc_i      (pc_i),
    .reg_wr_i  (reg_wr_i),
    .mem_wr_i  (mem_wr_i),
    .wb_data_i (wb_data_i),
    .st_data_i (st_data_i),
    .cpu_en_o  (cpu_en_o),
    .halted_o  (halted_o),
    .state_o   (state_o),
    .icount_o  (icount_o),
    .display_o (display_o)
  );

  always #5 clk = ~clk;

  // Logs the cycle index (negedge after posedge cyc) of every visible enable.
  always @(posedge clk) begin
    if (cpu_en_o) begin
      en_cnt = en_cnt + 1;
      en_times.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("halt_reached", 32'(halted_o), 32'd1);
  endtask

  task automatic clear_pulse();
    clr_i = 1'b1;
    cycles(1);
    clr_i = 1'b0;
  endtask

  task automatic press(output int press_cyc, input int hold, input int gap);
    step_i    = 1'b1;
    press_cyc = cyc;
    cycles(hold);
    step_i = 1'b0;
    cycles(gap);
  endtask

  function automatic logic [31:0] disp_model(input logic rw, input logic mw, input logic [31:0] wb,
                                             input logic [31:0] st, input logic [31:0] pc);
    if (rw) return wb;
    if (mw) return st;
    return pc;
  endfunction

  initial begin
    int t0, n0, b0, k;
    int pcyc[3];
    logic [31:0] exp_d;

    // Reset state
    cycles(3);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_en", 32'(cpu_en_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_icount", 32'(icount_o), 32'd0);
    check("rst_display", display_o, 32'd0);
    rst = 1'b1;
    cycles(1);

    // 1: free run at full rate up to the limit
    n0 = en_cnt;
    b0 = en_times.size();
    run_i = 1'b1;
    t0 = cyc;
    wait_halt(MaxCycles + 100);
    cycles(1);
    check("limit_en_count", 32'(en_cnt - n0), 32'(MaxCycles));
    check("limit_icount", 32'(icount_o), 32'(MaxCycles));
    check("limit_state", 32'(state_o), 32'd3);
    check("limit_first_en", 32'(en_times[b0]), 32'(t0 + 2));
    check("limit_last_en", 32'(en_times[en_times.size() - 1]), 32'(t0 + 1 + MaxCycles));
    // At the limit neither a step nor a run rise may issue anything.
    n0 = en_cnt;
    press(k, 2, 6);
    run_i = 1'b0;
    cycles(2);
    run_i = 1'b1;
    cycles(4);
    check("limit_no_more_en", 32'(en_cnt - n0), 32'd0);
    check("limit_stays_halt", 32'(state_o), 32'd3);
    run_i = 1'b0;
    clear_pulse();
    check("clr_state", 32'(state_o), 32'd0);
    check("clr_icount", 32'(icount_o), 32'd0);
    check("clr_halted", 32'(halted_o), 32'd0);

    // 2: three step presses with random hold/gap
    n0 = en_cnt;
    b0 = en_times.size();
    for (int i = 0; i < 3; i++) begin
      press(pcyc[i], int'($urandom_range(1, 3)), int'($urandom_range(3, 6)));
    end
    cycles(2);
    check("step_en_count", 32'(en_cnt - n0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("step_en_time", 32'(en_times[b0 + i]), 32'(pcyc[i] + 3));
    end
    check("step_icount", 32'(icount_o), 32'd3);
    check("step_state", 32'(state_o), 32'd0);

    // 3: breakpoint at 0x3010, then resume past it
    clear_pulse();
    cpu_mode  = 1'b1;
    bp_en_i   = 1'b1;
    bp_addr_i = 32'h0000_3010;
    n0 = en_cnt;
    run_i = 1'b1;
    wait_halt(100);
    cycles(1);
    check("bp_en_count", 32'(en_cnt - n0), 32'd4);
    check("bp_icount", 32'(icount_o), 32'd4);
    check("bp_state", 32'(state_o), 32'd3);
    run_i = 1'b0;
    cycles(2);
    run_i = 1'b1;
    cycles(10);
    check("resume_icount", 32'(icount_o), 32'd13);
    check("resume_state", 32'(state_o), 32'd1);

    // 4: rate_sel=1 spacing from a fresh RUN entry, then clear mid-run
    run_i = 1'b0;
    clear_pulse();
    bp_en_i    = 1'b0;
    rate_sel_i = 2'd1;
    b0 = en_times.size();
    run_i = 1'b1;
    t0 = cyc;
    k = 0;
    while (en_times.size() < b0 + 3 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("rate_en_seen", 32'(en_times.size() >= b0 + 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("rate_en_time", 32'(en_times[b0 + i]), 32'(t0 + 1 + (i + 1) * (1 << DivShift)));
    end
    check("rate_icount", 32'(icount_o), 32'd3);
    clear_pulse();
    check("clr_run_state", 32'(state_o), 32'd0);
    check("clr_run_icount", 32'(icount_o), 32'd0);
    check("clr_run_en", 32'(cpu_en_o), 32'd0);
    run_i      = 1'b0;
    rate_sel_i = 2'd0;
    cpu_mode   = 1'b0;
    cycles(2);

    // 5: display mux, directed then random; clr must not disturb it
    for (int i = 0; i < 15; i++) begin
      case (i)
        0: begin reg_wr_i = 1'b1; mem_wr_i = 1'b0; wb_data_i = 32'hDEAD_BEEF; end
        1: begin reg_wr_i = 1'b0; mem_wr_i = 1'b1; st_data_i = 32'h0000_1234; end
        2: begin reg_wr_i = 1'b0; mem_wr_i = 1'b0; pc_drv = 32'h0000_3004; end
        default: begin
          reg_wr_i  = 1'($urandom_range(0, 1));
          mem_wr_i  = 1'($urandom_range(0, 1));
          wb_data_i = $urandom;
          st_data_i = $urandom;
          pc_drv    = $urandom;
        end
      endcase
      clr_i = (i == 2);
      exp_d = disp_model(reg_wr_i, mem_wr_i, wb_data_i, st_data_i, pc_drv);
      cycles(1);
      check("display", display_o, exp_d);
    end
    clr_i = 1'b0;

    // 6: asynchronous reset between edges in the middle of a run
    run_i = 1'b1;
    cycles(int'($urandom_range(5, 20)));
    check("pre_rst_state", 32'(state_o), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_en", 32'(cpu_en_o), 32'd0);
    check("arst_icount", 32'(icount_o), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    run_i = 1'b0;
    rst   = 1'b1;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt controller for the single-cycle MIPS core on the board. Generates a one-clock-wide clock-enable for the CPU, counts executed instructions and enforces a cycle limit. It also halts on a PC breakpoint and selects the 32-bit value shown on the seg7x16 display. It sits between the board switches and buttons, the MIPS core and seg7x16, and replaces the free-running clk_div path.

Parameters:
MAX_CYCLES, 2048, executed-instruction limit; reaching it forces HALT.
DIV_SHIFT, 8, prescaler exponent step per rate_sel code.
CNT_W, 32, width of the instruction counter.

Ports:
clk  in  1  board clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset
run_i  in  1  level switch: 1 = free-run request
step_i  in  1  step button, already debounced, asynchronous to clk
clr_i  in  1  synchronous clear: counter to 0, state to IDLE
rate_sel_i  in  2  free-run speed select
bp_en_i  in  1  breakpoint enable
bp_addr_i  in  32  breakpoint PC
pc_i  in  32  CPU current PC
reg_wr_i  in  1  CPU register-write control
mem_wr_i  in  1  CPU memory-write control
wb_data_i  in  32  CPU register write-back data
st_data_i  in  32  CPU store data (rt value)
cpu_en_o  out  1  one-cycle CPU clock enable
halted_o  out  1  1 while in HALT
state_o  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
icount_o  out  CNT_W  instructions executed
display_o  out  32  value for seg7x16

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cpu_en_o=0, halted_o=0, icount_o=0, display_o=0, prescaler=0, step synchroniser=0, resume_skip=0.
- step_i passes through a 2-flop synchroniser. The step request is the rising edge of the synchronised value, so a press is recognised 3 clocks after the input rises.
- Prescaler tick:
  - rate_sel=0: tick every clock.
  - otherwise: tick when the low rate_sel*DIV_SHIFT bits of a free-running counter are all 1.
  - The counter clears on entry to RUN.
- cpu_en_o is registered. It is high for exactly one clock per issued instruction.
- icount_o increments in the same clock that cpu_en_o is high, saturating at MAX_CYCLES.
- IDLE:
  - run_i=1 -> RUN.
  - Else a step request -> STEP.
  - No enables are issued.
- RUN: on each tick, evaluate in this priority order:
  1. icount == MAX_CYCLES -> HALT, no enable.
  2. bp_en_i && pc_i == bp_addr_i && !resume_skip -> HALT, no enable.
  3. Otherwise issue an enable and clear resume_skip.
  - run_i=0 with no tick pending -> IDLE.
- STEP:
  - Issues exactly one enable in the clock after entry, then returns to IDLE.
  - The breakpoint check is skipped.
  - The limit check still applies: if icount == MAX_CYCLES, go to HALT without issuing an enable.
- HALT:
  - halted_o=1 and no enables are issued.
  - A step request issues one enable (if below the limit) and stays in HALT.
  - A rising edge of run_i (registered), with icount < MAX_CYCLES -> RUN, and resume_skip is set so the breakpoint instruction executes once.
  - At the limit, only clr_i leaves HALT.
- clr_i:
  - Has priority over all transitions.
  - Next clock: state=IDLE, icount=0, resume_skip=0, cpu_en_o=0.
  - display_o is not affected.
- display_o is registered, 1 clock latency, updated every clock:
  - reg_wr_i ? wb_data_i
  - : mem_wr_i ? st_data_i
  - : pc_i.
- Simultaneous step request and run_i rise in IDLE: RUN wins and the step request is dropped.
- Reset asserted mid-RUN: cpu_en_o drops immediately (asynchronous). No partial enable pulse is permitted.

Test Plan:
1. Reset, then run_i=1 with rate_sel=0 -> cpu_en_o high every clock; icount_o reaches 2048; state HALT, halted_o=1; no further enables.
2. From IDLE, three step presses -> exactly three single-clock cpu_en_o pulses, each 3 clocks after its press edge; icount_o=3; state returns to IDLE.
3. bp_en_i=1, bp_addr_i=0x0000_3010, pc_i stepping by 4 from 0x3000 -> HALT with 4 enables issued. Re-raising run_i -> the enable at 0x3010 is issued and running continues.
4. rate_sel=1 in RUN -> enables spaced exactly 256 clocks apart. clr_i mid-run -> icount_o=0 and IDLE next clock.
5. Display mux, 1-clock lag:
   - reg_wr_i=1, wb=0xDEAD_BEEF -> display 0xDEADBEEF.
   - reg_wr_i=0, mem_wr_i=1, st=0x1234 -> display 0x1234.
   - both 0, pc=0x3004 -> display 0x3004.
6. rst driven low asynchronously mid-RUN between clock edges -> cpu_en_o, icount_o and state cleared before the next edge.
